// File: rtl/sha_pkg.sv
// Shared constants and types for the double SHA-256 message feeder:
// IV words, padding word, block phase codes and the feeder state enum.
package sha_pkg;

  localparam logic [31:0] H1_IV = 32'h6a09e667;
  localparam logic [31:0] H2_IV = 32'hbb67ae85;
  localparam logic [31:0] H3_IV = 32'h3c6ef372;
  localparam logic [31:0] H4_IV = 32'ha54ff53a;
  localparam logic [31:0] H5_IV = 32'h510e527f;
  localparam logic [31:0] H6_IV = 32'h9b05688c;
  localparam logic [31:0] H7_IV = 32'h1f83d9ab;
  localparam logic [31:0] H8_IV = 32'h5be0cd19;

  localparam logic [31:0] PAD_WORD = 32'h80000000;

  localparam logic [1:0] BLK_IDLE = 2'd0;
  localparam logic [1:0] BLK_1    = 2'd1;
  localparam logic [1:0] BLK_2    = 2'd2;
  localparam logic [1:0] BLK_3    = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FEED1,
    ST_WAIT1,
    ST_FEED2,
    ST_WAIT2,
    ST_CAP,
    ST_FEED3,
    ST_WAIT3,
    ST_FIN
  } feed_state_t;

endpackage

// File: rtl/sha_pad_mux.sv
// Combinational message word select for blocks 1..3 of the double hash.
// Optional macro NONCE_OVERRIDE_EN replaces header word 19 with the nonce input.
module sha_pad_mux
  import sha_pkg::*;
#(
  parameter logic [31:0] LEN_HDR = 32'd640,
  parameter logic [31:0] LEN_DIG = 32'd256
) (
  input  logic [1:0]   block,
  input  logic [3:0]   idx,
  input  logic [31:0]  hdr_data,
`ifdef NONCE_OVERRIDE_EN
  input  logic [31:0]  nonce,
`endif
  input  logic [255:0] dig,
  output logic [31:0]  word
);

  logic [31:0] dig_word;

  always_comb begin
    case (idx[2:0])
      3'd0:    dig_word = dig[255:224];
      3'd1:    dig_word = dig[223:192];
      3'd2:    dig_word = dig[191:160];
      3'd3:    dig_word = dig[159:128];
      3'd4:    dig_word = dig[127:96];
      3'd5:    dig_word = dig[95:64];
      3'd6:    dig_word = dig[63:32];
      default: dig_word = dig[31:0];
    endcase
  end

  always_comb begin
    word = '0;
    case (block)
      BLK_1: word = hdr_data;
      BLK_2: begin
        if (idx < 4'd4) begin
`ifdef NONCE_OVERRIDE_EN
          word = (idx == 4'd3) ? nonce : hdr_data;
`else
          word = hdr_data;
`endif
        end else if (idx == 4'd4) begin
          word = PAD_WORD;
        end else if (idx == 4'd15) begin
          word = LEN_HDR;
        end
      end
      BLK_3: begin
        if (!idx[3])             word = dig_word;
        else if (idx == 4'd8)    word = PAD_WORD;
        else if (idx == 4'd15)   word = LEN_DIG;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/sha_msg_feeder.sv
// Streams the three message blocks of a bitcoin double SHA-256 to the compressor.
// Optional macro NONCE_OVERRIDE_EN adds nonce/auto_next inputs for back-to-back runs.
module sha_msg_feeder
  import sha_pkg::*;
#(
  parameter logic [31:0] LEN_HDR = 32'd640,
  parameter logic [31:0] LEN_DIG = 32'd256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [4:0]   hdr_addr,
  input  logic [31:0]  hdr_data,
  input  logic [255:0] digest,
  input  logic         comp_done,
  input  logic         w_ready,
  output logic         w_valid,
  output logic [31:0]  w_data,
  output logic [3:0]   w_idx,
  output logic [1:0]   block,
  output logic         done,
  output logic         busy
`ifdef NONCE_OVERRIDE_EN
  ,
  input  logic [31:0]  nonce,
  input  logic         auto_next
`endif
);

  feed_state_t  state, state_d;
  logic [1:0]   block_d;
  logic         busy_d, done_d, w_valid_d, cap_q, cap_d;
  logic [3:0]   w_idx_d, ld_idx;
  logic [31:0]  w_data_d, mux_word;
  logic [4:0]   hdr_addr_d, nxt_addr, nxt_ext;
  logic [255:0] dig_q, dig_d;
  logic         feeding, load, last_xfer;

  // The word being loaded into the output register is always one ahead of w_idx.
  assign ld_idx    = w_valid ? (w_idx + 4'd1) : 4'd0;
  assign feeding   = (state == ST_FEED1) || (state == ST_FEED2) || (state == ST_FEED3);
  assign last_xfer = feeding && w_valid && w_ready && (w_idx == 4'hF);
  assign load      = feeding && (!w_valid || (w_ready && (w_idx != 4'hF)));
  assign nxt_ext   = {1'b0, ld_idx} + 5'd1;

  // hdr_addr is registered one word ahead so hdr_data is ready when that word loads.
  always_comb begin
    nxt_addr = hdr_addr;
    if (block == BLK_1)                          nxt_addr = nxt_ext;
    else if (block == BLK_2 && nxt_ext < 5'd4)   nxt_addr = 5'd16 + nxt_ext;
  end

  sha_pad_mux #(.LEN_HDR(LEN_HDR), .LEN_DIG(LEN_DIG)) u_mux (
    .block    (block),
    .idx      (ld_idx),
    .hdr_data (hdr_data),
`ifdef NONCE_OVERRIDE_EN
    .nonce    (nonce),
`endif
    .dig      (dig_q),
    .word     (mux_word)
  );

  always_comb begin
    state_d    = state;
    block_d    = block;
    busy_d     = busy;
    done_d     = 1'b0;
    w_valid_d  = w_valid;
    w_idx_d    = w_idx;
    w_data_d   = w_data;
    hdr_addr_d = hdr_addr;
    dig_d      = dig_q;
    cap_d      = 1'b0;
    if (load) begin
      w_valid_d  = 1'b1;
      w_idx_d    = ld_idx;
      w_data_d   = mux_word;
      hdr_addr_d = nxt_addr;
    end
    if (last_xfer) w_valid_d = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_d = ST_FEED1; block_d = BLK_1; busy_d = 1'b1; hdr_addr_d = 5'd0;
      end
      ST_FEED1: if (last_xfer) state_d = ST_WAIT1;
      ST_WAIT1: if (comp_done) begin
        state_d = ST_FEED2; block_d = BLK_2; hdr_addr_d = 5'd16;
      end
      ST_FEED2: if (last_xfer) state_d = ST_WAIT2;
      ST_WAIT2: if (comp_done) state_d = ST_CAP;
      // Two cycles in CAP let the accumulators settle before the digest is sampled.
      ST_CAP: begin
        if (!cap_q) begin
          cap_d = 1'b1;
        end else begin
          dig_d = digest; state_d = ST_FEED3; block_d = BLK_3;
        end
      end
      ST_FEED3: if (last_xfer) state_d = ST_WAIT3;
      ST_WAIT3: if (comp_done) begin
        state_d = ST_FIN; done_d = 1'b1; block_d = BLK_IDLE; busy_d = 1'b0;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
`ifdef NONCE_OVERRIDE_EN
        if (auto_next) begin
          state_d = ST_FEED1; block_d = BLK_1; busy_d = 1'b1; hdr_addr_d = 5'd0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      block    <= BLK_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      w_valid  <= 1'b0;
      w_idx    <= 4'd0;
      w_data   <= 32'd0;
      hdr_addr <= 5'd0;
      dig_q    <= '0;
      cap_q    <= 1'b0;
    end else begin
      state    <= state_d;
      block    <= block_d;
      busy     <= busy_d;
      done     <= done_d;
      w_valid  <= w_valid_d;
      w_idx    <= w_idx_d;
      w_data   <= w_data_d;
      hdr_addr <= hdr_addr_d;
      dig_q    <= dig_d;
      cap_q    <= cap_d;
    end
  end

endmodule

// File: tb/tb_sha_msg_feeder.sv
// Table-driven bench for sha_msg_feeder: expected 48-word stream plus reset/stall/spurious-input sequences.
module tb_sha_msg_feeder;
  import sha_pkg::*;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, comp_done = 1'b0, w_ready = 1'b0;
  logic [4:0]   hdr_addr;
  logic [31:0]  hdr_data;
  logic [255:0] digest;
  logic         w_valid, done, busy;
  logic [31:0]  w_data;
  logic [3:0]   w_idx;
  logic [1:0]   block;
`ifdef NONCE_OVERRIDE_EN
  logic [31:0]  nonce = 32'hDEADBEEF;
  logic         auto_next = 1'b0;
`endif

  always #5 clk = ~clk;

  assign hdr_data = {27'd0, hdr_addr};
  assign digest = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                   32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};

  sha_msg_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .digest(digest), .comp_done(comp_done), .w_ready(w_ready), .w_valid(w_valid),
    .w_data(w_data), .w_idx(w_idx), .block(block), .done(done), .busy(busy)
`ifdef NONCE_OVERRIDE_EN
    , .nonce(nonce), .auto_next(auto_next)
`endif
  );

  typedef struct {
    logic [1:0]  blk;
    logic [3:0]  idx;
    logic [31:0] data;
  } xfer_t;

  xfer_t      exp_tab [48];
  xfer_t      got [$];
  logic [1:0] blk_seq [$];
  int         total = 0, bad = 0;
  int         ready_mode = 0, cd_cnt = 0, done_cnt = 0;
  logic       force_cd = 1'b0;
  logic [1:0] last_blk = 2'd0;
  logic       prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_idx = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One clock: observe at the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    xfer_t x;
    @(posedge clk);
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_data", {32'd0, w_data}, {32'd0, prev_data});
      chk("stall_idx", {60'd0, w_idx}, {60'd0, prev_idx});
    end
    if (block != last_blk) begin
      blk_seq.push_back(block);
      last_blk = block;
    end
    if (done) done_cnt++;
    if (ready_mode == 0) w_ready = 1'b1;
    else                 w_ready = ~w_ready;
    comp_done = force_cd;
    if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) comp_done = 1'b1;
    end
    if (w_valid && w_ready) begin
      x.blk = block; x.idx = w_idx; x.data = w_data;
      got.push_back(x);
      if (w_idx == 4'hF) cd_cnt = 5;
    end
    prev_stall = w_valid && !w_ready;
    prev_data  = w_data;
    prev_idx   = w_idx;
  endtask

  task automatic run_to_done(input int budget, input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (done_cnt == d0) begin
      bad++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, budget);
    end
  endtask

  task automatic check_stream(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'd48);
    for (int i = 0; i < 48 && i < got.size(); i++)
      chk($sformatf("%s_word%0d", name, i), {26'd0, got[i].blk, got[i].idx, got[i].data},
          {26'd0, exp_tab[i].blk, exp_tab[i].idx, exp_tab[i].data});
  endtask

  task automatic check_blk_seq(input string name);
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
    chk({name, "_blkseq_len"}, 64'(blk_seq.size()), 64'd4);
    for (int i = 0; i < 4 && i < blk_seq.size(); i++)
      chk($sformatf("%s_blkseq%0d", name, i), {62'd0, blk_seq[i]}, {62'd0, want[i]});
  endtask

  task automatic clear_logs();
    got.delete();
    blk_seq.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    for (int i = 0; i < 16; i++) begin
      exp_tab[i].blk = 2'd1; exp_tab[i].idx = i[3:0]; exp_tab[i].data = 32'(i);
      exp_tab[16+i].blk = 2'd2; exp_tab[16+i].idx = i[3:0];
      exp_tab[16+i].data = (i < 4) ? 32'(16 + i) : (i == 4) ? 32'h80000000 :
                           (i == 15) ? 32'h00000280 : 32'h0;
      exp_tab[32+i].blk = 2'd3; exp_tab[32+i].idx = i[3:0];
      exp_tab[32+i].data = (i < 8) ? 32'h11111111 * 32'(i + 1) : (i == 8) ? 32'h80000000 :
                           (i == 15) ? 32'h00000100 : 32'h0;
    end
`ifdef NONCE_OVERRIDE_EN
    exp_tab[19].data = 32'hDEADBEEF;
`endif

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_block", {62'd0, block}, 64'd0);
    chk("rst_w_valid", {63'd0, w_valid}, 64'd0);
    chk("rst_w_idx", {60'd0, w_idx}, 64'd0);
    chk("rst_w_data", {32'd0, w_data}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hdr_addr", {59'd0, hdr_addr}, 64'd0);
    rst_n = 1'b1;
    tick();

    // comp_done while idle is ignored
    force_cd = 1'b1;
    tick();
    force_cd = 1'b0;
    tick();
    tick();
    chk("idle_cd_block", {62'd0, block}, 64'd0);
    chk("idle_cd_busy", {63'd0, busy}, 64'd0);
    chk("idle_cd_valid", {63'd0, w_valid}, 64'd0);

    // full run, w_ready high
    clear_logs();
    ready_mode = 0;
    pulse_start();
    chk("A_start_block", {62'd0, block}, 64'd1);
    chk("A_start_busy", {63'd0, busy}, 64'd1);
    chk("A_start_valid", {63'd0, w_valid}, 64'd0);
    tick();
    chk("A_first_valid", {63'd0, w_valid}, 64'd1);
    chk("A_first_idx", {60'd0, w_idx}, 64'd0);
    run_to_done(400, "A");
    chk("A_fin_block", {62'd0, block}, 64'd0);
    chk("A_fin_busy", {63'd0, busy}, 64'd0);
    tick();
    tick();
    chk("A_done_pulses", 64'(done_cnt), 64'd1);
    check_stream("A");
    check_blk_seq("A");

    // full run, w_ready toggling
    clear_logs();
    ready_mode = 1;
    pulse_start();
    run_to_done(600, "B");
    tick();
    tick();
    chk("B_done_pulses", 64'(done_cnt), 64'd1);
    check_stream("B");
    check_blk_seq("B");

    // reset in block 2 at idx 7, then replay
    clear_logs();
    ready_mode = 0;
    pulse_start();
    found = 0;
    for (int n = 0; n < 200 && found == 0; n++) begin
      tick();
      if (block == 2'd2 && w_valid && w_idx == 4'd7) found = 1;
    end
    chk("C_reached_b2i7", 64'(found), 64'd1);
    rst_n = 1'b0;
    cd_cnt = 0;
    tick();
    chk("C_rst_block", {62'd0, block}, 64'd0);
    chk("C_rst_valid", {63'd0, w_valid}, 64'd0);
    chk("C_rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;
    tick();
    clear_logs();
    pulse_start();
    run_to_done(400, "C");
    tick();
    check_stream("C");
    check_blk_seq("C");

    // spurious comp_done in FEED1 together with start while busy
    clear_logs();
    pulse_start();
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      tick();
      if (block == 2'd1 && w_valid && w_idx == 4'd3) found = 1;
    end
    chk("D_reached_b1i3", 64'(found), 64'd1);
    force_cd = 1'b1;
    tick();
    start = 1'b1;
    tick();
    force_cd = 1'b0;
    start = 1'b0;
    chk("D_block_hold", {62'd0, block}, 64'd1);
    chk("D_busy_hold", {63'd0, busy}, 64'd1);
    run_to_done(400, "D");
    tick();
    tick();
    chk("D_done_pulses", 64'(done_cnt), 64'd1);
    check_stream("D");
    check_blk_seq("D");

`ifdef NONCE_OVERRIDE_EN
    // auto restart straight from FIN
    clear_logs();
    auto_next = 1'b1;
    pulse_start();
    run_to_done(400, "E");
    chk("E_fin_block", {62'd0, block}, 64'd0);
    tick();
    chk("E_restart_block", {62'd1 - 62'd1, block}, 64'd1);
    chk("E_restart_busy", {63'd0, busy}, 64'd1);
    auto_next = 1'b0;
    run_to_done(400, "E2");
    tick();
    chk("E_stream_len", 64'(got.size()), 64'd96);
    chk("E_nonce_word", {32'd0, got[19].data}, 64'hDEADBEEF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
